// File: rtl/register_file_sb.sv
// Parametrised dual-read / single-write register file with a per-register
// busy scoreboard, optional same-cycle write bypass and hardwired zero register.
module register_file_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  READ,
  input  logic [ADDR_WIDTH-1:0] ADDR_R1,
  input  logic [ADDR_WIDTH-1:0] ADDR_R2,
  output logic [DATA_WIDTH-1:0] DATA_R1,
  output logic [DATA_WIDTH-1:0] DATA_R2,
  output logic                  BUSY_R1,
  output logic                  BUSY_R2,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] ADDR_W,
  input  logic [DATA_WIDTH-1:0] DATA_W,
  input  logic                  RESERVE,
  input  logic [ADDR_WIDTH-1:0] ADDR_RSV,
  output logic                  ANY_BUSY
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0]      busy_r;
  logic [DEPTH-1:0]      busy_nxt_s;
  logic                  wr_en_s;
  logic                  rsv_en_s;
  logic [ADDR_WIDTH-1:0] ra_s    [2];
  logic [DATA_WIDTH-1:0] rdata_s [2];
  logic                  rbusy_s [2];

  function automatic logic is_zero_reg(input logic [ADDR_WIDTH-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign ra_s[0]  = ADDR_R1;
  assign ra_s[1]  = ADDR_R2;
  assign ANY_BUSY = |busy_r;

  // Write/reserve qualification and next scoreboard; a reserve overrides a same-cycle clear.
  always_comb begin
    wr_en_s    = WRITE && !is_zero_reg(ADDR_W);
    rsv_en_s   = RESERVE && !is_zero_reg(ADDR_RSV);
    busy_nxt_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_nxt_s[i] = (rsv_en_s && (ADDR_RSV == ADDR_WIDTH'(i))) ||
                      (busy_r[i] && !(wr_en_s && (ADDR_W == ADDR_WIDTH'(i))));
    end
  end

  // Read-port data/busy selection: post-edge view with bypass, pre-edge view without.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata_s[p] = '0;
      rbusy_s[p] = 1'b0;
      if (is_zero_reg(ra_s[p])) begin
        rdata_s[p] = '0;
        rbusy_s[p] = 1'b0;
      end else if (BYPASS != 0) begin
        rdata_s[p] = (WRITE && (ADDR_W == ra_s[p])) ? DATA_W : mem_r[ra_s[p]];
        rbusy_s[p] = busy_nxt_s[ra_s[p]];
      end else begin
        rdata_s[p] = mem_r[ra_s[p]];
        rbusy_s[p] = busy_r[ra_s[p]] || (rsv_en_s && (ADDR_RSV == ra_s[p]));
      end
    end
  end

  // Register array, scoreboard and registered read outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      busy_r  <= '0;
      DATA_R1 <= '0;
      DATA_R2 <= '0;
      BUSY_R1 <= 1'b0;
      BUSY_R2 <= 1'b0;
    end else begin
      if (wr_en_s) begin
        mem_r[ADDR_W] <= DATA_W;
      end
      busy_r <= busy_nxt_s;
      if (READ) begin
        DATA_R1 <= rdata_s[0];
        DATA_R2 <= rdata_s[1];
        BUSY_R1 <= rbusy_s[0];
        BUSY_R2 <= rbusy_s[1];
      end
    end
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Randomised bench for register_file_sb: three configurations share one stimulus
// stream and are compared every cycle against a post-/pre-edge state model.
module tb_register_file_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd = 1'b0, wr = 1'b0, rsv = 1'b0;
  logic [4:0]  a1 = 5'd0, a2 = 5'd0, aw = 5'd0, ar = 5'd0;
  logic [31:0] dw = 32'd0;

  logic [31:0] d1_0, d2_0, d1_1, d2_1;
  logic [15:0] d1_2, d2_2;
  logic        b1_0, b2_0, b1_1, b2_1, b1_2, b2_2;
  logic        any_0, any_1, any_2;

  int tests = 0;
  int failed = 0;

  // model state per configuration: 0 = default, 1 = no zero reg / no bypass, 2 = 16x8
  logic [31:0] m_mem  [3][32];
  logic [31:0] m_busy [3];
  logic [31:0] m_d1 [3], m_d2 [3];
  logic        m_b1 [3], m_b2 [3];
  int          amask [3] = '{31, 31, 7};
  logic [31:0] dmask [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF};
  bit          zr    [3] = '{1'b1, 1'b0, 1'b0};
  bit          bp    [3] = '{1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  register_file_sb u0 (
    .CLK(clk), .RST(rst), .READ(rd), .ADDR_R1(a1), .ADDR_R2(a2),
    .DATA_R1(d1_0), .DATA_R2(d2_0), .BUSY_R1(b1_0), .BUSY_R2(b2_0),
    .WRITE(wr), .ADDR_W(aw), .DATA_W(dw), .RESERVE(rsv), .ADDR_RSV(ar),
    .ANY_BUSY(any_0));

  register_file_sb #(.ZERO_REG(0), .BYPASS(0)) u1 (
    .CLK(clk), .RST(rst), .READ(rd), .ADDR_R1(a1), .ADDR_R2(a2),
    .DATA_R1(d1_1), .DATA_R2(d2_1), .BUSY_R1(b1_1), .BUSY_R2(b2_1),
    .WRITE(wr), .ADDR_W(aw), .DATA_W(dw), .RESERVE(rsv), .ADDR_RSV(ar),
    .ANY_BUSY(any_1));

  register_file_sb #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .ZERO_REG(0), .BYPASS(1)) u2 (
    .CLK(clk), .RST(rst), .READ(rd), .ADDR_R1(a1[2:0]), .ADDR_R2(a2[2:0]),
    .DATA_R1(d1_2), .DATA_R2(d2_2), .BUSY_R1(b1_2), .BUSY_R2(b2_2),
    .WRITE(wr), .ADDR_W(aw[2:0]), .DATA_W(dw[15:0]), .RESERVE(rsv), .ADDR_RSV(ar[2:0]),
    .ANY_BUSY(any_2));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      for (int r = 0; r < 32; r++) m_mem[c][r] = 32'd0;
      m_busy[c] = 32'd0;
      m_d1[c] = 32'd0; m_d2[c] = 32'd0;
      m_b1[c] = 1'b0;  m_b2[c] = 1'b0;
    end
  endtask

  // Apply one rising edge to the model: new state first, then each read port
  // sees either the new state (bypass) or the old state plus a fresh reserve.
  task automatic model_step();
    for (int c = 0; c < 3; c++) begin
      int wa, ra, r1, r2;
      bit wok, rok;
      logic [31:0] old_mem [32];
      logic [31:0] old_busy;
      wa = int'(aw) & amask[c];
      ra = int'(ar) & amask[c];
      r1 = int'(a1) & amask[c];
      r2 = int'(a2) & amask[c];
      wok = wr && !(zr[c] && wa == 0);
      rok = rsv && !(zr[c] && ra == 0);
      old_mem = m_mem[c];
      old_busy = m_busy[c];
      if (wok) begin
        m_mem[c][wa] = dw & dmask[c];
        m_busy[c][wa] = 1'b0;
      end
      if (rok) m_busy[c][ra] = 1'b1;
      if (rd) begin
        for (int p = 0; p < 2; p++) begin
          int a;
          logic [31:0] d;
          logic b;
          a = (p == 0) ? r1 : r2;
          if (zr[c] && a == 0) begin
            d = 32'd0; b = 1'b0;
          end else if (bp[c]) begin
            d = m_mem[c][a]; b = m_busy[c][a];
          end else begin
            d = old_mem[a]; b = old_busy[a] | (rok && ra == a);
          end
          if (p == 0) begin m_d1[c] = d; m_b1[c] = b; end
          else        begin m_d2[c] = d; m_b2[c] = b; end
        end
      end
    end
  endtask

  task automatic compare_all();
    check("u0.DATA_R1", d1_0, m_d1[0]);
    check("u0.DATA_R2", d2_0, m_d2[0]);
    check("u0.BUSY_R1", {31'd0, b1_0}, {31'd0, m_b1[0]});
    check("u0.BUSY_R2", {31'd0, b2_0}, {31'd0, m_b2[0]});
    check("u0.ANY_BUSY", {31'd0, any_0}, {31'd0, |m_busy[0]});
    check("u1.DATA_R1", d1_1, m_d1[1]);
    check("u1.DATA_R2", d2_1, m_d2[1]);
    check("u1.BUSY_R1", {31'd0, b1_1}, {31'd0, m_b1[1]});
    check("u1.BUSY_R2", {31'd0, b2_1}, {31'd0, m_b2[1]});
    check("u1.ANY_BUSY", {31'd0, any_1}, {31'd0, |m_busy[1]});
    check("u2.DATA_R1", {16'd0, d1_2}, m_d1[2]);
    check("u2.DATA_R2", {16'd0, d2_2}, m_d2[2]);
    check("u2.BUSY_R1", {31'd0, b1_2}, {31'd0, m_b1[2]});
    check("u2.BUSY_R2", {31'd0, b2_2}, {31'd0, m_b2[2]});
    check("u2.ANY_BUSY", {31'd0, any_2}, {31'd0, |m_busy[2][7:0]});
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic step(input logic i_rd, input logic [4:0] i_a1, input logic [4:0] i_a2,
                      input logic i_wr, input logic [4:0] i_aw, input logic [31:0] i_dw,
                      input logic i_rsv, input logic [4:0] i_ar);
    rd = i_rd; a1 = i_a1; a2 = i_a2;
    wr = i_wr; aw = i_aw; dw = i_dw;
    rsv = i_rsv; ar = i_ar;
    cycle();
  endtask

  // Assert reset between edges, check immediate clearing, release on a falling edge.
  task automatic mid_reset();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b1;

    // reset clears stored data
    step(1'b1, 5'd5, 5'd5, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0);
    check("lit.bypass_r5", d1_0, 32'hDEAD_BEEF);
    mid_reset();
    check("lit.rst_immediate", d1_0, 32'h0);
    step(1'b1, 5'd5, 5'd5, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    check("lit.r5_after_rst", d1_0, 32'h0);
    check("lit.any_after_rst", {31'd0, any_0}, 32'd0);

    // basic write then read, then hold
    step(1'b0, 5'd0, 5'd0, 1'b1, 5'd7, 32'h1234_5678, 1'b0, 5'd0);
    step(1'b1, 5'd7, 5'd7, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    check("lit.r7_p1", d1_0, 32'h1234_5678);
    check("lit.r7_p2", d2_0, 32'h1234_5678);
    step(1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    check("lit.hold", d1_0, 32'h1234_5678);

    // same-cycle write and read
    step(1'b1, 5'd3, 5'd0, 1'b1, 5'd3, 32'hA5A5_A5A5, 1'b0, 5'd0);
    check("lit.bypass_on", d1_0, 32'hA5A5_A5A5);
    check("lit.bypass_off", d1_1, 32'h0);
    step(1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    check("lit.bypass_off_next", d1_1, 32'hA5A5_A5A5);

    // scoreboard
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    step(1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    check("lit.r9_busy", {31'd0, b1_0}, 32'd1);
    check("lit.r9_any", {31'd0, any_0}, 32'd1);
    step(1'b1, 5'd9, 5'd0, 1'b1, 5'd9, 32'h55, 1'b0, 5'd0);
    check("lit.r9_clear_busy", {31'd0, b1_0}, 32'd0);
    check("lit.r9_clear_data", d1_0, 32'h55);
    check("lit.r9_clear_any", {31'd0, any_0}, 32'd0);
    step(1'b0, 5'd0, 5'd0, 1'b1, 5'd9, 32'h66, 1'b1, 5'd9);
    step(1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    check("lit.rsv_wins_busy", {31'd0, b1_0}, 32'd1);
    check("lit.rsv_wins_data", d1_0, 32'h66);
    step(1'b0, 5'd0, 5'd0, 1'b1, 5'd9, 32'h0, 1'b0, 5'd0);

    // zero register
    step(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0);
    step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    check("lit.zr_data", d1_0, 32'h0);
    check("lit.zr_busy", {31'd0, b1_0}, 32'd0);
    check("lit.zr_any", {31'd0, any_0}, 32'd0);
    check("lit.nozr_data", d1_1, 32'hFFFF_FFFF);
    check("lit.nozr_busy", {31'd0, b1_1}, 32'd1);

    // narrow configuration and address wrap
    step(1'b1, 5'd7, 5'd0, 1'b1, 5'd7, 32'h0000_BEEF, 1'b0, 5'd0);
    check("lit.w16_r7", {16'd0, d1_2}, 32'h0000_BEEF);
    step(1'b0, 5'd0, 5'd0, 1'b1, 5'd8, 32'h0000_1234, 1'b0, 5'd0);
    step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    check("lit.w16_wrap", {16'd0, d1_2}, 32'h0000_1234);

    // randomised traffic with occasional reset
    for (int n = 0; n < 800; n++) begin
      logic [4:0] ad [4];
      for (int k = 0; k < 4; k++) begin
        ad[k] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      end
      if ($urandom_range(0, 149) == 0) begin
        mid_reset();
      end else begin
        step(1'($urandom_range(0, 3) != 0), ad[0], ad[1],
             1'($urandom_range(0, 1)), ad[2], $urandom,
             1'($urandom_range(0, 2) == 0), ad[3]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
